// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a two-entry instruction queue.
// The pc register drives the combinational instruction memory directly. Each
// accepted word is queued with its address and presented to decode from the
// head entry registers. Redirects flush the queue and reload pc.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When defined, a misaligned
// redirect target raises fetch_misalign and halts fetch until an aligned
// redirect arrives. When undefined, redirect targets are word-aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_misalign
);

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

  // The queue is built as an explicit head/tail register pair, so only
  // depth 2 is meaningful.
  generate
    if (QDEPTH != 2) begin : g_qdepth_unsupported
      $error("fetch_unit supports QDEPTH == 2 only");
    end
  endgenerate

  // Queue occupancy; HALT exists only with misalignment checking.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    ST_HALT
`endif
  } occ_t;

  occ_t        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;

  logic pop;
  logic push;
  logic halted;

  assign imem_addr = pc_q;
  assign if_valid  = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign if_pc     = head_pc_q;
  assign if_instr  = head_instr_q;

`ifdef FETCH_MISALIGN_CHK_EN
  assign halted         = (state_q == ST_HALT);
  assign fetch_misalign = (state_q == ST_HALT);
`else
  assign halted         = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign pop  = if_valid && if_ready;
  assign push = ((state_q != ST_FULL) || pop) && !redirect_valid && !halted;

  // Next-state logic: occupancy, pc and queue entry updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (redirect_valid) begin
      // Any pop this cycle has already been taken by decode; the rest of
      // the queue is simply abandoned by marking it empty.
      state_d = ST_EMPTY;
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_HALT;
        pc_d    = redirect_pc;
      end
`endif
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_rdata;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && push) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_rdata;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else if (push) begin
            tail_pc_d    = pc_q;
            tail_instr_d = imem_rdata;
            state_d      = ST_FULL;
          end
        end
        ST_FULL: begin
          // Push is only possible alongside a pop here; the tail moves to
          // the head and the new word takes the tail slot.
          if (pop) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            if (push) begin
              tail_pc_d    = pc_q;
              tail_instr_d = imem_rdata;
            end else begin
              state_d = ST_ONE;
            end
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        ST_HALT: begin
          state_d = ST_HALT;
        end
`endif
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      pc_q         <= PC_INIT;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for the fetch queue corner cases,
// an asynchronous reset pulse, then randomized traffic checked against a
// queue-based reference model of the fetch stage.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_misalign;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .fetch_misalign(fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word i holds value i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed vectors: expected outputs at this negedge, then inputs for the
  // following rising edge.
  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic emis, input logic rv, input logic [31:0] rpc,
                     input logic rdy);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.emis = emis;
    vecs.push_back(v);
  endtask

  // Reference model: ordered list of fetched {pc, instr}, plus fetch pc.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_halt;

  task automatic model_edge(input logic rv, input logic [31:0] rpc, input logic rdy);
    ent_t e;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      m_pc   = rpc;
      m_halt = (rpc % 4) != 0;
`else
      m_pc = rpc - (rpc % 4);
`endif
    end else if (mq.size() < 2 && !m_halt) begin
      e.pc    = m_pc;
      e.instr = mem_word(m_pc);
      mq.push_back(e);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic model_check();
    chk("m_valid", {31'd0, if_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("m_if_pc", if_pc, mq[0].pc);
      chk("m_if_instr", if_instr, mq[0].instr);
    end
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_misalign", {31'd0, fetch_misalign}, {31'd0, m_halt});
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;

    // Table: stall after reset, drain, redirect while full, wrap, back-to-back
    // redirects, misaligned redirect.
    add(0, 32'h0,         32'h0,         0, 0, 32'h0,         0);
    add(1, 32'h0,         32'h4,         0, 0, 32'h0,         0);
    add(1, 32'h0,         32'h8,         0, 0, 32'h0,         0);
    add(1, 32'h0,         32'h8,         0, 0, 32'h0,         0);
    add(1, 32'h0,         32'h8,         0, 0, 32'h0,         0);
    add(1, 32'h0,         32'h8,         0, 0, 32'h0,         1);
    add(1, 32'h4,         32'hC,         0, 0, 32'h0,         1);
    add(1, 32'h8,         32'h10,        0, 0, 32'h0,         1);
    add(1, 32'hC,         32'h14,        0, 0, 32'h0,         1);
    add(1, 32'h10,        32'h18,        0, 1, 32'h100,       1);
    add(0, 32'h0,         32'h100,       0, 0, 32'h0,         1);
    add(1, 32'h100,       32'h104,       0, 0, 32'h0,         1);
    add(1, 32'h104,       32'h108,       0, 1, 32'hFFFF_FFF8, 1);
    add(0, 32'h0,         32'hFFFF_FFF8, 0, 0, 32'h0,         1);
    add(1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 0, 32'h0,         1);
    add(1, 32'hFFFF_FFFC, 32'h0,         0, 0, 32'h0,         1);
    add(1, 32'h0,         32'h4,         0, 1, 32'h300,       1);
    add(0, 32'h0,         32'h300,       0, 1, 32'h500,       1);
    add(0, 32'h0,         32'h500,       0, 0, 32'h0,         1);
    add(1, 32'h500,       32'h504,       0, 1, 32'h102,       1);
`ifdef FETCH_MISALIGN_CHK_EN
    add(0, 32'h0,         32'h102,       1, 0, 32'h0,         1);
    add(0, 32'h0,         32'h102,       1, 0, 32'h0,         1);
    add(0, 32'h0,         32'h102,       1, 1, 32'h200,       1);
    add(0, 32'h0,         32'h200,       0, 0, 32'h0,         1);
    add(1, 32'h200,       32'h204,       0, 0, 32'h0,         1);
`else
    add(0, 32'h0,         32'h100,       0, 0, 32'h0,         1);
    add(1, 32'h100,       32'h104,       0, 1, 32'h200,       1);
    add(0, 32'h0,         32'h200,       0, 0, 32'h0,         1);
    add(1, 32'h200,       32'h204,       0, 0, 32'h0,         1);
`endif

    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_if_pc", i), if_pc, vecs[i].epc);
        chk($sformatf("v%0d_if_instr", i), if_instr, vecs[i].epc >> 2);
      end
      chk($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_misalign", i), {31'd0, fetch_misalign}, {31'd0, vecs[i].emis});
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      if_ready       = vecs[i].rdy;
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset pulse between edges while the queue is busy.
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_if_pc", if_pc, 32'h0);
    chk("arst_if_instr", if_instr, 32'h0);
    chk("arst_misalign", {31'd0, fetch_misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    mq.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      model_check();
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc[31:4] = 28'hFFFF_FFF;
      rdy = ($urandom_range(0, 9) < 7);
      redirect_valid = rv;
      redirect_pc    = rpc;
      if_ready       = rdy;
      model_edge(rv, rpc, rdy);
      @(posedge clk);
      @(negedge clk);
    end
    model_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
